// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
// Decodes the RV32I/RV64I immediate formats (I, S, B, U, J), the CSR zimm
// and the shift amount, then carries each immediate with a sideband tag
// through a 2-entry skid buffer with valid/ready on both sides.
// Optional feature macro: IMM_GEN_ILLEGAL_CHK_EN (adds the imm_err output).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] tag_out
`ifdef IMM_GEN_ILLEGAL_CHK_EN
    ,
    output logic             imm_err
`endif
);

`ifdef IMM_GEN_ILLEGAL_CHK_EN
    localparam int CHK_W = 1;
`else
    localparam int CHK_W = 0;
`endif
    // One buffer entry is {err (if present), tag, immediate}.
    localparam int EW = XLEN + TAG_W + CHK_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } occ_e;

    // Build the extended immediate: fill with the sign (or zero) first,
    // then overwrite the low bits with the format's field layout.
    function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] ins,
                                                   input logic [2:0]  src);
        logic [XLEN-1:0] r;
        r = {XLEN{1'b0}};
        case (src)
            3'b000: begin
                r       = {XLEN{ins[31]}};
                r[11:0] = ins[31:20];
            end
            3'b001: begin
                r       = {XLEN{ins[31]}};
                r[11:0] = {ins[31:25], ins[11:7]};
            end
            3'b010: begin
                r       = {XLEN{ins[31]}};
                r[12:0] = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            3'b011: begin
                r       = {XLEN{ins[31]}};
                r[31:0] = {ins[31:12], 12'h000};
            end
            3'b100: begin
                r       = {XLEN{ins[31]}};
                r[20:0] = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            3'b101: begin
                r[4:0] = ins[19:15];
            end
            3'b110: begin
                if (XLEN == 32) begin
                    r[4:0] = ins[24:20];
                end else begin
                    r[5:0] = ins[25:20];
                end
            end
            default: begin
                r = {XLEN{1'b0}};
            end
        endcase
        return r;
    endfunction

`ifdef IMM_GEN_ILLEGAL_CHK_EN
    // Reserved format, or a shift amount of 32..63 on a 32-bit datapath.
    function automatic logic illegal_imm(input logic [31:0] ins,
                                         input logic [2:0]  src);
        logic e;
        e = 1'b0;
        if (src == 3'b111) begin
            e = 1'b1;
        end else if ((XLEN == 32) && (src == 3'b110) && ins[25]) begin
            e = 1'b1;
        end else begin
            e = 1'b0;
        end
        return e;
    endfunction
`endif

    occ_e          state_r, state_nxt_s;
    logic          out_valid_r, out_valid_nxt_s;
    logic [EW-1:0] head_r, head_nxt_s;
    logic [EW-1:0] tail_r, tail_nxt_s;
    logic [EW-1:0] new_entry_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          pop_s;

`ifdef IMM_GEN_ILLEGAL_CHK_EN
    assign new_entry_s = {illegal_imm(instr, imm_src), tag_in, decode_imm(instr, imm_src)};
`else
    assign new_entry_s = {tag_in, decode_imm(instr, imm_src)};
`endif

    // Input is refused during reset, during a flush, and when both slots are used.
    assign in_ready_s = rst_n && !flush && (state_r != ST_FULL);
    assign accept_s   = in_valid && in_ready_s;
    assign pop_s      = out_valid_r && out_ready;

    // Next occupancy and slot contents; the head slot always drives the outputs.
    always_comb begin
        state_nxt_s     = state_r;
        out_valid_nxt_s = out_valid_r;
        head_nxt_s      = head_r;
        tail_nxt_s      = tail_r;
        if (flush) begin
            state_nxt_s     = ST_EMPTY;
            out_valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_nxt_s      = new_entry_s;
                        state_nxt_s     = ST_ONE;
                        out_valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        head_nxt_s = new_entry_s;
                    end else if (accept_s) begin
                        tail_nxt_s  = new_entry_s;
                        state_nxt_s = ST_FULL;
                    end else if (pop_s) begin
                        state_nxt_s     = ST_EMPTY;
                        out_valid_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        head_nxt_s  = tail_r;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s     = ST_EMPTY;
                    out_valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State and slot registers; reset clears everything, including the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            head_r      <= {EW{1'b0}};
            tail_r      <= {EW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign imm_out   = head_r[XLEN-1:0];
    assign tag_out   = head_r[XLEN +: TAG_W];
`ifdef IMM_GEN_ILLEGAL_CHK_EN
    assign imm_err   = head_r[EW-1];
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit and a 64-bit instance share
// the same stimulus; each accepted input pushes its expected result and a
// monitor pops and compares whenever an output is taken downstream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [7:0]  tag_in;
    logic        flush;
    logic        out_ready;

    logic        in_ready32, out_valid32;
    logic [31:0] imm32;
    logic [7:0]  tag32;
    logic        in_ready64, out_valid64;
    logic [63:0] imm64;
    logic [7:0]  tag64;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
    logic        err32, err64;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_src(imm_src), .tag_in(tag_in), .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready), .imm_out(imm32), .tag_out(tag32)
`ifdef IMM_GEN_ILLEGAL_CHK_EN
        , .imm_err(err32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_src(imm_src), .tag_in(tag_in), .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready), .imm_out(imm64), .tag_out(tag64)
`ifdef IMM_GEN_ILLEGAL_CHK_EN
        , .imm_err(err64)
`endif
    );

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;

    localparam int NV = 11;
    logic [31:0] v_instr [0:NV-1] = '{32'hFFF00093, 32'hFE512E23, 32'hFE000CE3, 32'h123450B7,
                                      32'h001000EF, 32'h800000B7, 32'h000FD073, 32'h03F01093,
                                      32'h01F01093, 32'h12345678, 32'h7FF00013};
    logic [2:0]  v_src   [0:NV-1] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd5, 3'd6, 3'd6, 3'd7, 3'd0};
    logic [31:0] v_e32   [0:NV-1] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                      32'h00000800, 32'h80000000, 32'h0000001F, 32'h0000001F,
                                      32'h0000001F, 32'h00000000, 32'h000007FF};
    logic [63:0] v_e64   [0:NV-1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                      64'h0000000012345000, 64'h0000000000000800, 64'hFFFFFFFF80000000,
                                      64'h000000000000001F, 64'h000000000000003F, 64'h000000000000001F,
                                      64'h0000000000000000, 64'h00000000000007FF};
    logic        v_er32  [0:NV-1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        v_er64  [0:NV-1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; holds the input until accepted.
    task automatic send(input int idx, input logic [7:0] t);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        instr    = v_instr[idx];
        imm_src  = v_src[idx];
        tag_in   = t;
        for (int n = 0; n < 50 && !acc; n++) begin
            #1;
            if (in_ready32 && in_ready64) begin
                acc = 1'b1;
                q32.push_back('{imm: {32'h0, v_e32[idx]}, tag: t, err: v_er32[idx]});
                q64.push_back('{imm: v_e64[idx], tag: t, err: v_er64[idx]});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("send_accepted", {63'h0, acc}, 64'h1);
    endtask

    // Monitor: compare every output taken downstream against the queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid32 && out_ready) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected32: tag %0h emitted, expected no output", tag32);
                end else begin
                    e = q32.pop_front();
                    check("imm32", {32'h0, imm32}, e.imm);
                    check("tag32", {56'h0, tag32}, {56'h0, e.tag});
`ifdef IMM_GEN_ILLEGAL_CHK_EN
                    check("err32", {63'h0, err32}, {63'h0, e.err});
`endif
                end
            end
            if (rst_n && out_valid64 && out_ready) begin
                if (q64.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected64: tag %0h emitted, expected no output", tag64);
                end else begin
                    e = q64.pop_front();
                    check("imm64", imm64, e.imm);
                    check("tag64", {56'h0, tag64}, {56'h0, e.tag});
`ifdef IMM_GEN_ILLEGAL_CHK_EN
                    check("err64", {63'h0, err64}, {63'h0, e.err});
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0; imm_src = 3'd0;
        tag_in = 8'h0; flush = 1'b0; out_ready = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_in_ready", {63'h0, in_ready32}, 64'h0);
        check("rst_out_valid", {63'h0, out_valid32}, 64'h0);
        check("rst_imm32", {32'h0, imm32}, 64'h0);
        check("rst_tag32", {56'h0, tag32}, 64'h0);
        check("rst_imm64", imm64, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // First-transaction latency
        out_ready = 1'b1;
        send(0, 8'hA0);
        #1;
        check("lat_out_valid", {63'h0, out_valid32}, 64'h1);
        check("lat_imm32", {32'h0, imm32}, 64'hFFFFFFFF);
        @(negedge clk);

        // All formats back-to-back
        for (int i = 0; i < NV; i++) begin
            send(i, 8'(i));
        end
        repeat (3) @(negedge clk);

        // Backpressure: tags 1 and 2 fill the buffer, tag 3 waits upstream
        out_ready = 1'b0;
        send(3, 8'd1);
        send(4, 8'd2);
        in_valid = 1'b1; instr = v_instr[1]; imm_src = v_src[1]; tag_in = 8'd3;
        #1;
        check("full_in_ready", {63'h0, in_ready32}, 64'h0);
        check("full_head_tag", {56'h0, tag32}, 64'h1);
        @(negedge clk); #1;
        check("full_hold_tag", {56'h0, tag32}, 64'h1);
        check("full_hold_imm", {32'h0, imm32}, 64'h12345000);
        @(negedge clk);
        out_ready = 1'b1;
        send(1, 8'd3);
        repeat (4) @(negedge clk);

        // Flush with a full buffer and a concurrent input
        out_ready = 1'b0;
        send(5, 8'h21);
        send(6, 8'h22);
        in_valid = 1'b1; instr = v_instr[0]; imm_src = v_src[0]; tag_in = 8'h77;
        flush = 1'b1;
        #1;
        check("flush_in_ready", {63'h0, in_ready32}, 64'h0);
        #2;
        q32.delete(); q64.delete();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_valid", {63'h0, out_valid32}, 64'h0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        send(2, 8'h30);
        repeat (3) @(negedge clk);

        // Reset with a full buffer
        out_ready = 1'b0;
        send(7, 8'h41);
        send(9, 8'h42);
        rst_n = 1'b0;
        q32.delete(); q64.delete();
        @(negedge clk); #1;
        check("rst2_out_valid", {63'h0, out_valid32}, 64'h0);
        check("rst2_imm32", {32'h0, imm32}, 64'h0);
        check("rst2_tag32", {56'h0, tag32}, 64'h0);
        check("rst2_imm64", imm64, 64'h0);
        check("rst2_in_ready", {63'h0, in_ready32}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(9, 8'h50);
        send(7, 8'h51);

        // Drain whatever remains, bounded
        for (int n = 0; n < 100 && (q32.size() != 0 || q64.size() != 0); n++) begin
            @(negedge clk);
        end
        #3;
        check("drain_q32", 64'(q32.size()), 64'h0);
        check("drain_q64", 64'(q64.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
